// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions.
// Holds the 640x480@60 axis constants, sync polarity constants, the
// timing field bundle carried between the timer and its decoder, and a
// helper that sums a field bundle into a period length.
// The struct fields are sized for the widest supported axis
// (TIMING_MAX_W). Narrower axes zero-extend into it, and synthesis prunes
// the constant-zero upper bits.
package vga_timing_pkg;

    localparam int TIMING_MAX_W = 16;
    // Two extra bits so that four maximal fields can be summed without overflow.
    localparam int TOTAL_W      = TIMING_MAX_W + 2;

    // 640x480@60 horizontal timing, in pixel ticks.
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    // 640x480@60 vertical timing, in lines.
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        logic [TIMING_MAX_W-1:0] active;
        logic [TIMING_MAX_W-1:0] fp;
        logic [TIMING_MAX_W-1:0] sync;
        logic [TIMING_MAX_W-1:0] bp;
    } timing_fields_t;

    // Period length T = active + fp + sync + bp, computed without overflow.
    function automatic logic [TOTAL_W-1:0] timing_total(input timing_fields_t f);
        return TOTAL_W'(f.active) + TOTAL_W'(f.fp) + TOTAL_W'(f.sync) + TOTAL_W'(f.bp);
    endfunction

endpackage

// File: rtl/vga_axis_timer_if.sv
// Signal bundle for one VGA axis timer.
// master: the block driving the advance tick and the config strobe
//         (a testbench, a register block, or the upstream axis).
// slave:  the timer itself.
// cfg_load is a single-cycle strobe with no back-pressure. A valid load is
// always accepted into the pending set, and an invalid one is answered by
// a one-cycle cfg_err pulse.
//   tick                               advance enable
//   cfg_load, cfg_active/fp/sync/bp    config strobe and new fields
//   sync, video_on, pos                registered timing outputs
//   last                               combinational wrap indicator (chain input)
//   cfg_pending, cfg_err               config status
interface vga_axis_timer_if #(
    parameter int WIDTH = 10
);
    logic             tick;
    logic             cfg_load;
    logic [WIDTH-1:0] cfg_active;
    logic [WIDTH-1:0] cfg_fp;
    logic [WIDTH-1:0] cfg_sync;
    logic [WIDTH-1:0] cfg_bp;
    logic             sync;
    logic             video_on;
    logic [WIDTH-1:0] pos;
    logic             last;
    logic             cfg_pending;
    logic             cfg_err;

    modport master (
        output tick, cfg_load, cfg_active, cfg_fp, cfg_sync, cfg_bp,
        input  sync, video_on, pos, last, cfg_pending, cfg_err
    );

    modport slave (
        input  tick, cfg_load, cfg_active, cfg_fp, cfg_sync, cfg_bp,
        output sync, video_on, pos, last, cfg_pending, cfg_err
    );
endinterface

// File: rtl/vga_axis_decode.sv
// Combinational region decode for one VGA axis.
// Maps a counter value and a timing field set to sync / video_on / pos.
// The timer feeds it the *next* count and *next* active set, so the
// registered outputs line up with the count they describe.
//   count    in  WIDTH      position in the period
//   fields   in  struct     active/fp/sync/bp of the governing set
//   sync     out 1          sync level, polarity set by SYNC_POL
//   video_on out 1          count inside the active region
//   pos      out WIDTH      count inside the active region, else 0
module vga_axis_decode
    import vga_timing_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic [WIDTH-1:0] count,
    input  timing_fields_t   fields,
    output logic             sync,
    output logic             video_on,
    output logic [WIDTH-1:0] pos
);

    logic [TOTAL_W-1:0] k;
    logic [TOTAL_W-1:0] active_end;
    logic [TOTAL_W-1:0] sync_start;
    logic [TOTAL_W-1:0] sync_end;
    logic               in_active;
    logic               in_sync;

    always_comb begin
        k          = TOTAL_W'(count);
        active_end = TOTAL_W'(fields.active);
        sync_start = active_end + TOTAL_W'(fields.fp);
        // The sync region ends where the back porch begins, B ticks before the wrap.
        sync_end   = timing_total(fields) - TOTAL_W'(fields.bp);
        in_active  = (k < active_end);
        in_sync    = (k >= sync_start) && (k < sync_end);
        video_on   = in_active;
        pos        = in_active ? count : '0;
        sync       = in_sync ? SYNC_POL : ~SYNC_POL;
    end

endmodule

// File: rtl/vga_axis_timer.sv
// Run-time reconfigurable timing generator for one VGA axis.
// A period is active, front porch, sync, back porch. The counter advances on
// bus.tick. Chain a vertical instance to a horizontal one by driving its
// tick with (pixel_tick & h.last).
// New timing fields are staged in a pending set and swap in only on a wrap,
// so a mode change never tears a line or frame.
//   clk    in  1        clock
//   reset  in  1        synchronous, active-high
//   bus    slave        tick, cfg_* in; sync, video_on, pos, last,
//                       cfg_pending, cfg_err out
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int ACTIVE   = 480,
    parameter int FP       = 10,
    parameter int SYNC     = 2,
    parameter int BP       = 33,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
    input logic              clk,
    input logic              reset,
    vga_axis_timer_if.slave  bus
);

    if (WIDTH < 1 || WIDTH > TIMING_MAX_W || ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 ||
        (ACTIVE + FP + SYNC + BP) > (1 << WIDTH)) begin : g_bad_params
        $error("vga_axis_timer: illegal timing parameters");
    end

    localparam timing_fields_t DEFAULT_SET = '{
        active: TIMING_MAX_W'(ACTIVE),
        fp:     TIMING_MAX_W'(FP),
        sync:   TIMING_MAX_W'(SYNC),
        bp:     TIMING_MAX_W'(BP)
    };
    localparam logic [TOTAL_W-1:0] MAX_TOTAL = TOTAL_W'(1) << WIDTH;

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    timing_fields_t   active_set;
    timing_fields_t   active_set_next;
    timing_fields_t   pending_set;
    logic             pending_q;
    timing_fields_t   cfg_fields;
    logic             cfg_valid;
    logic             wrap;

    logic             sync_q;
    logic             video_on_q;
    logic [WIDTH-1:0] pos_q;
    logic             cfg_err_q;
    logic             sync_d;
    logic             video_on_d;
    logic [WIDTH-1:0] pos_d;

    always_comb begin
        cfg_fields = '{
            active: TIMING_MAX_W'(bus.cfg_active),
            fp:     TIMING_MAX_W'(bus.cfg_fp),
            sync:   TIMING_MAX_W'(bus.cfg_sync),
            bp:     TIMING_MAX_W'(bus.cfg_bp)
        };
        cfg_valid = (bus.cfg_active != '0) && (bus.cfg_fp != '0) &&
                    (bus.cfg_sync != '0) && (bus.cfg_bp != '0) &&
                    (timing_total(cfg_fields) <= MAX_TOTAL);
    end

    always_comb begin
        wrap = bus.tick &&
               (TOTAL_W'(count) == (timing_total(active_set) - TOTAL_W'(1)));
        if (wrap) begin
            count_next = '0;
        end else if (bus.tick) begin
            count_next = count + WIDTH'(1);
        end else begin
            count_next = count;
        end
        // The pending set takes over exactly at count 0 of the new period.
        active_set_next = (wrap && pending_q) ? pending_set : active_set;
    end

    // The outputs register the decode of the next count under the next set,
    // so in any cycle they describe the current count.
    vga_axis_decode #(
        .WIDTH    (WIDTH),
        .SYNC_POL (SYNC_POL)
    ) u_decode (
        .count    (count_next),
        .fields   (active_set_next),
        .sync     (sync_d),
        .video_on (video_on_d),
        .pos      (pos_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            active_set <= DEFAULT_SET;
            sync_q     <= ~SYNC_POL;
            video_on_q <= 1'b1;
            pos_q      <= '0;
        end else begin
            count      <= count_next;
            active_set <= active_set_next;
            sync_q     <= sync_d;
            video_on_q <= video_on_d;
            pos_q      <= pos_d;
        end
    end

    // A load coinciding with a wrap lands in pending after the current
    // pending set (if any) has swapped in, so it waits for the next wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_set <= DEFAULT_SET;
            pending_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_load && !cfg_valid;
            if (bus.cfg_load && cfg_valid) begin
                pending_set <= cfg_fields;
                pending_q   <= 1'b1;
            end else if (wrap) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign bus.sync        = sync_q;
    assign bus.video_on    = video_on_q;
    assign bus.pos         = pos_q;
    assign bus.last        = wrap;
    assign bus.cfg_pending = pending_q;
    assign bus.cfg_err     = cfg_err_q;

endmodule

// File: doc/vga_axis_timer.md
# vga_axis_timer

Parametrised, run-time reconfigurable timing generator for one VGA axis, horizontal or vertical. It replaces the fixed vertical-only counter. One instance advances per pixel tick and produces the horizontal timing. A second instance advances on `pixel_tick & h_last` and produces the vertical timing. Timing fields are held in shadow registers and swap in only at an axis wrap, so mode changes never tear a line or frame.

## Interface
Parameters:
- `WIDTH`, 10, width of counter, position and config fields.
- `ACTIVE`, 480, reset-default visible length in ticks.
- `FP`, 10, reset-default front porch.
- `SYNC`, 2, reset-default sync pulse length.
- `BP`, 33, reset-default back porch.
- `SYNC_POL`, 0, sync polarity: 1 = active-high, 0 = active-low.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: advance enable.
- `cfg_load` in 1: one-cycle request to stage the `cfg_*` values.
- `cfg_active`, `cfg_fp`, `cfg_sync`, `cfg_bp` in WIDTH each: new timing fields.
- `sync` out 1: registered sync, polarity set by `SYNC_POL`.
- `video_on` out 1: registered, high while in the active region.
- `pos` out WIDTH: registered position within the active region, 0 outside it.
- `last` out 1: combinational, `tick && count == total-1`. Used as the chain input for the next axis.
- `cfg_pending` out 1: a staged config is waiting for the next wrap.
- `cfg_err` out 1: one-cycle pulse when `cfg_load` is rejected.

## Operation
- Region order within a period: active [0, A), front porch [A, A+F), sync [A+F, A+F+S), back porch [A+F+S, T). T = A+F+S+B.
- Internal `count` runs 0..T-1 and advances only when `tick` is high. On `tick` at T-1 it wraps to 0.
- Outputs are a registered decode of `count`. In any cycle where `count = k`, the outputs show the decode of k.
  - `video_on = (k < A)`.
  - `pos = k` when `k < A`, else 0.
  - `sync = SYNC_POL` when k is in the sync region, else `!SYNC_POL`.
- Config path:
  - On `cfg_load`, validate the fields. Every field must be ≥ 1 and T must be ≤ 2^WIDTH. T is computed in WIDTH+2 bits.
  - Valid: copy the fields into the pending registers and set `cfg_pending`. A later load overwrites an earlier pending one.
  - Invalid: pending registers are unchanged and `cfg_err` pulses.
- Config swap:
  - On a wrap (`last`) with `cfg_pending` set, the active set takes the pending values and `cfg_pending` clears.
  - The new set governs from `count = 0` of the next period.
- Simultaneous `cfg_load` and wrap: the new values go to pending and are applied at the following wrap, not this one.
- Reset at any point:
  - `count` = 0 and the active set returns to the parameter defaults.
  - Pending is cleared, so `cfg_pending` = 0.
  - Outputs: `video_on` = 1, `pos` = 0, `sync` = `!SYNC_POL`, `cfg_err` = 0.
  - An in-flight `cfg_load` in the reset cycle is discarded.
- Legal parameters (all ≥ 1, sum ≤ 2^WIDTH) are a precondition. Violation is an elaboration error.

## Timing
- `count` and the registered outputs change in the cycle after `tick` is sampled: a latency of 1 from `tick` to the new decode.
- `last` is combinational from `tick` and the current `count`, so a chained axis advances in the same cycle as the wrap.
- `cfg_err` and `cfg_pending` update one cycle after `cfg_load`.
- No `tick` means no state change, except the config staging path.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the 640x480@60 constants: H 640/16/96/48, V 480/10/2/33;
  - polarity constants `SYNC_ACTIVE_LOW`/`SYNC_ACTIVE_HIGH`;
  - a parametric `timing_fields_t` struct {active, fp, sync, bp}.
- One sub-module, `vga_axis_decode`: purely combinational, maps (count, active set) to the next-state values of `sync`, `video_on` and `pos`. It is instantiated once.
- Config shadow and counter stay in the top module.

## Test plan
- Vertical defaults, `tick` every cycle:
  - count 479: `video_on` = 1, `pos` = 479.
  - count 480: `video_on` = 0, `pos` = 0.
  - counts 490–491: `sync` = 0; counts 489 and 492: `sync` = 1.
  - `last` high on count 524 only.
- Chained pair, H 640/16/96/48 and V 480/10/2/33: the vertical count advances exactly once per 800 pixel ticks, and one frame is 420 000 ticks.
- `cfg_load` 320/8/48/24 at horizontal count 100:
  - `cfg_pending` = 1 until the wrap at 799.
  - The next period has T = 400 and sync at 328..375.
  - `cfg_pending` = 0 after the swap.
- `cfg_load` in the same cycle as `last`: the current period wraps with the old T, one full old-length period follows, and the new T applies after that.
- `cfg_load` with `cfg_sync` = 0, or with `WIDTH` = 10 and fields summing to 1025: `cfg_err` pulses once and the timing is unchanged.
- Reset asserted mid-line at count 600 with a config pending: next cycle count = 0, `video_on` = 1, `sync` inactive, `cfg_pending` = 0, and the default timing resumes.
